// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game slice: match-controller state
// encoding, screen geometry and a small integer helper.
package pong_pkg;

  // Match controller state encoding (visible on the state debug output)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4,
    ST_PAUSE = 3'd5
  } match_state_e;

  // Screen and object geometry used by the ball/paddle datapath
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BALL_SIZE     = 8;
  localparam int PADDLE_WIDTH  = 8;
  localparam int PADDLE_HEIGHT = 64;
  localparam int CENTER_X      = SCREEN_WIDTH / 2;
  localparam int CENTER_Y      = SCREEN_HEIGHT / 2;

  // Larger of two integers, used to size shared counters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Loadable frame down-counter with a zero flag. Shared by the serve and
// point delays of the match controller. Decrement saturates at zero.
module pong_frame_timer #(
  parameter int W = 8
) (
  input  logic         clk_div,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Count register: load has priority over decrement
  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong game-flow controller, one tick per video frame on clk_div.
// Sequences serve, play, point pause and game over; converts collision
// and miss events into ball commands and keeps the two scores.
// Optional macro PONG_PAUSE_EN enables the pause state (encoding 5);
// without it pause_btn is ignored and state 5 falls back to IDLE.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 30,
  parameter int POINT_DELAY = 60,
  parameter int SCORE_W     = 4
) (
  input  logic               clk_div,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               left_hit,
  input  logic               right_hit,
  input  logic               wall_hit,
  input  logic               left_miss,
  input  logic               right_miss,
  output logic               ball_center,
  output logic               ball_run,
  output logic               flip_x,
  output logic               flip_y,
  output logic               serve_dir_x,
  output logic [SCORE_W-1:0] score_player,
  output logic [SCORE_W-1:0] score_opp,
  output logic [2:0]         state,
  output logic               game_over,
  output logic               winner
);

  localparam int TW = $clog2(max_int(SERVE_DELAY, POINT_DELAY) + 1);
  localparam logic [TW-1:0]      SERVE_LOAD = TW'(SERVE_DELAY - 1);
  localparam logic [TW-1:0]      POINT_LOAD = TW'(POINT_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

  match_state_e       r_state, w_next_state;
  logic               r_start_q;
  logic               w_start_rise;
  logic               r_ball_center, r_ball_run, r_flip_x, r_flip_y;
  logic               r_serve_dir_x, r_game_over, r_winner;
  logic [SCORE_W-1:0] r_score_p, r_score_o;
  logic [SCORE_W-1:0] w_score_p_next, w_score_o_next;
  logic               w_dir_next, w_flip_x_next, w_flip_y_next;
  logic               w_lmiss, w_rmiss;
  logic               w_load, w_dec, w_timer_zero;
  logic [TW-1:0]      w_load_val;
  logic               w_pause_rise;

  assign w_start_rise = start_btn & ~r_start_q;
  // A miss on a side that is also hit this frame is a save, not a point
  assign w_lmiss = left_miss & ~left_hit;
  assign w_rmiss = right_miss & ~right_hit;

`ifdef PONG_PAUSE_EN
  logic r_pause_q;

  // Pause button edge-detect register
  always_ff @(posedge clk_div) begin
    if (!rst_n) r_pause_q <= 1'b0;
    else        r_pause_q <= pause_btn;
  end

  assign w_pause_rise = pause_btn & ~r_pause_q;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause_btn;
  assign w_pause_rise   = 1'b0;
`endif

  pong_frame_timer #(
    .W (TW)
  ) u_timer (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_timer_zero)
  );

  // State register and start edge-detect register
  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_start_q <= start_btn;
    end
  end

  // Next-state, timer control and next values of scores/flips/direction
  always_comb begin
    w_next_state   = r_state;
    w_load         = 1'b0;
    w_load_val     = '0;
    w_dec          = 1'b0;
    w_score_p_next = r_score_p;
    w_score_o_next = r_score_o;
    w_dir_next     = r_serve_dir_x;
    w_flip_x_next  = 1'b0;
    w_flip_y_next  = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_rise) begin
          w_next_state   = ST_SERVE;
          w_load         = 1'b1;
          w_load_val     = SERVE_LOAD;
          w_score_p_next = '0;
          w_score_o_next = '0;
          w_dir_next     = 1'b1;
        end
      end
      ST_SERVE: begin
        if (w_timer_zero) w_next_state = ST_PLAY;
        else              w_dec        = 1'b1;
      end
      ST_PLAY: begin
        if (w_pause_rise) begin
          w_next_state = ST_PAUSE;
        end else if (w_lmiss) begin
          w_next_state   = ST_POINT;
          w_load         = 1'b1;
          w_load_val     = POINT_LOAD;
          w_dir_next     = 1'b0;
          if (r_score_p < WIN_S) w_score_p_next = r_score_p + SCORE_W'(1);
        end else if (w_rmiss) begin
          w_next_state   = ST_POINT;
          w_load         = 1'b1;
          w_load_val     = POINT_LOAD;
          w_dir_next     = 1'b1;
          if (r_score_o < WIN_S) w_score_o_next = r_score_o + SCORE_W'(1);
        end else begin
          // A flip on the previous frame blocks a repeat on the same axis
          w_flip_x_next = (left_hit | right_hit) & ~r_flip_x;
          w_flip_y_next = wall_hit & ~r_flip_y;
        end
      end
      ST_POINT: begin
        if (w_timer_zero) begin
          if ((r_score_p == WIN_S) || (r_score_o == WIN_S)) begin
            w_next_state = ST_OVER;
          end else begin
            w_next_state = ST_SERVE;
            w_load       = 1'b1;
            w_load_val   = SERVE_LOAD;
          end
        end else begin
          w_dec = 1'b1;
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSE: begin
        if (w_pause_rise) w_next_state = ST_PLAY;
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      r_ball_center <= 1'b1;
      r_ball_run    <= 1'b0;
      r_flip_x      <= 1'b0;
      r_flip_y      <= 1'b0;
      r_serve_dir_x <= 1'b1;
      r_score_p     <= '0;
      r_score_o     <= '0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
    end else begin
      r_ball_center <= (w_next_state != ST_PLAY) && (w_next_state != ST_PAUSE);
      r_ball_run    <= (w_next_state == ST_PLAY);
      r_flip_x      <= w_flip_x_next;
      r_flip_y      <= w_flip_y_next;
      r_serve_dir_x <= w_dir_next;
      r_score_p     <= w_score_p_next;
      r_score_o     <= w_score_o_next;
      r_game_over   <= (w_next_state == ST_OVER);
      r_winner      <= (w_next_state == ST_OVER) && (w_score_p_next == WIN_S);
    end
  end

  assign ball_center  = r_ball_center;
  assign ball_run     = r_ball_run;
  assign flip_x       = r_flip_x;
  assign flip_y       = r_flip_y;
  assign serve_dir_x  = r_serve_dir_x;
  assign score_player = r_score_p;
  assign score_opp    = r_score_o;
  assign state        = r_state;
  assign game_over    = r_game_over;
  assign winner       = r_winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl with default parameters
// (WIN_SCORE=9, SERVE_DELAY=30, POINT_DELAY=60, SCORE_W=4).
module tb_pong_match_ctrl;

  logic       clk_div = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0, pause_btn = 1'b0;
  logic       left_hit = 1'b0, right_hit = 1'b0, wall_hit = 1'b0;
  logic       left_miss = 1'b0, right_miss = 1'b0;
  logic       ball_center, ball_run, flip_x, flip_y, serve_dir_x;
  logic [3:0] score_player, score_opp;
  logic [2:0] state;
  logic       game_over, winner;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       lh, rh, wh, lm, rm;
    logic [2:0] st;
    logic       fx, fy, run;
    int         sp, so;
    logic       dir;
  } vec_t;

  vec_t vecs[9];

  pong_match_ctrl dut (
    .clk_div      (clk_div),
    .rst_n        (rst_n),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .left_hit     (left_hit),
    .right_hit    (right_hit),
    .wall_hit     (wall_hit),
    .left_miss    (left_miss),
    .right_miss   (right_miss),
    .ball_center  (ball_center),
    .ball_run     (ball_run),
    .flip_x       (flip_x),
    .flip_y       (flip_y),
    .serve_dir_x  (serve_dir_x),
    .score_player (score_player),
    .score_opp    (score_opp),
    .state        (state),
    .game_over    (game_over),
    .winner       (winner)
  );

  // clock
  always #5 clk_div = ~clk_div;

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input int target, input int bound, input string nm);
    int n = 0;
    while ((int'(state) != target) && (n < bound)) begin
      tick();
      n++;
    end
    chk(nm, int'(state), target);
  endtask

  initial begin
    // vectors applied one frame each, starting in PLAY with scores 0:0
    vecs[0] = '{"hit_wall_both", 0,1,1,0,0, 3'd2, 1,1,1, 0,0, 1};
    vecs[1] = '{"rehit_supp",    0,1,0,0,0, 3'd2, 0,0,1, 0,0, 1};
    vecs[2] = '{"quiet",         0,0,0,0,0, 3'd2, 0,0,1, 0,0, 1};
    vecs[3] = '{"left_hit",      1,0,0,0,0, 3'd2, 1,0,1, 0,0, 1};
    vecs[4] = '{"wall_only",     0,0,1,0,0, 3'd2, 0,1,1, 0,0, 1};
    vecs[5] = '{"wall_supp",     0,0,1,0,0, 3'd2, 0,0,1, 0,0, 1};
    vecs[6] = '{"rhit_rmiss",    0,1,0,0,1, 3'd2, 1,0,1, 0,0, 1};
    vecs[7] = '{"lhit_lmiss",    1,0,0,1,0, 3'd2, 0,0,1, 0,0, 1};
    vecs[8] = '{"both_miss",     0,0,0,1,1, 3'd3, 0,0,0, 1,0, 0};

    // reset
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_center", ball_center, 1);
    chk("rst_run", ball_run, 0);
    chk("rst_flips", {flip_x, flip_y}, 0);
    chk("rst_dir", serve_dir_x, 1);
    chk("rst_scores", {score_player, score_opp}, 0);
    chk("rst_over", {game_over, winner}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", state, 0);

    // start -> SERVE for 30 frames -> PLAY
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk("serve_entry", state, 1);
    chk("serve_center", ball_center, 1);
    for (int i = 1; i < 30; i++) begin
      tick();
      chk("serve_hold", state, 1);
    end
    tick();
    chk("play_state", state, 2);
    chk("play_run", ball_run, 1);
    chk("play_center", ball_center, 0);
    chk("play_dir", serve_dir_x, 1);

    // table-driven PLAY vectors
    for (int i = 0; i < 9; i++) begin
      left_hit = vecs[i].lh; right_hit = vecs[i].rh; wall_hit = vecs[i].wh;
      left_miss = vecs[i].lm; right_miss = vecs[i].rm;
      tick();
      chk({vecs[i].name, "_state"}, state, vecs[i].st);
      chk({vecs[i].name, "_fx"}, flip_x, vecs[i].fx);
      chk({vecs[i].name, "_fy"}, flip_y, vecs[i].fy);
      chk({vecs[i].name, "_run"}, ball_run, vecs[i].run);
      chk({vecs[i].name, "_sp"}, score_player, vecs[i].sp);
      chk({vecs[i].name, "_so"}, score_opp, vecs[i].so);
      chk({vecs[i].name, "_dir"}, serve_dir_x, vecs[i].dir);
    end
    {left_hit, right_hit, wall_hit, left_miss, right_miss} = '0;

    // POINT lasts 60 frames, then SERVE toward the loser
    for (int i = 1; i < 60; i++) begin
      tick();
      chk("point_hold", state, 3);
    end
    tick();
    chk("point_to_serve", state, 1);
    chk("point_serve_dir", serve_dir_x, 0);
    for (int i = 1; i < 30; i++) tick();
    tick();
    chk("serve2_play", state, 2);
    chk("serve2_dir", serve_dir_x, 0);

`ifdef PONG_PAUSE_EN
    pause_btn = 1'b1;
    tick();
    chk("pause_state", state, 5);
    chk("pause_run", ball_run, 0);
    chk("pause_center", ball_center, 0);
    left_miss = 1'b1;
    tick();
    left_miss = 1'b0;
    chk("pause_miss_ign", score_player, 1);
    chk("pause_held", state, 5);
    pause_btn = 1'b0;
    tick();
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
    chk("unpause_state", state, 2);
    chk("unpause_run", ball_run, 1);
`else
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
    chk("nopause_state", state, 2);
    chk("nopause_run", ball_run, 1);
`endif

    // start_btn ignored during play
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk("start_in_play", state, 2);

    // opponent scores nine points -> OVER
    for (int k = 1; k <= 9; k++) begin
      wait_state(2, 200, "reach_play");
      right_miss = 1'b1;
      tick();
      right_miss = 1'b0;
      chk("opp_score", score_opp, k);
      chk("opp_point", state, 3);
    end
    wait_state(4, 100, "reach_over");
    chk("over_flag", game_over, 1);
    chk("over_winner", winner, 0);
    chk("over_sp", score_player, 1);
    right_miss = 1'b1;
    left_miss = 1'b1;
    tick();
    tick();
    tick();
    right_miss = 1'b0;
    left_miss = 1'b0;
    chk("over_hold_so", score_opp, 9);
    chk("over_hold_sp", score_player, 1);
    chk("over_hold_st", state, 4);

    // restart from OVER
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_scores", {score_player, score_opp}, 0);
    chk("restart_dir", serve_dir_x, 1);
    chk("restart_over", game_over, 0);

    // reset mid-game
    wait_state(2, 40, "restart_play");
    left_miss = 1'b1;
    tick();
    left_miss = 1'b0;
    chk("pre_rst_sp", score_player, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_state", state, 0);
    chk("midrst_sp", score_player, 0);
    chk("midrst_center", ball_center, 1);
    chk("midrst_dir", serve_dir_x, 1);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
